// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS.t BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } sw_state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DigitMax9 = 4'd9;
    localparam bcd_t DigitMax5 = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Button/tick inputs and BCD display outputs of the stopwatch.
interface stopwatch_bcd_if;
    import stopwatch_pkg::*;

    logic tick_in;
    logic start_stop;
    logic clear;
    logic lap;
    bcd_t tenths;
    bcd_t sec_u;
    bcd_t sec_t;
    bcd_t min_u;
    bcd_t min_t;
    logic running;
    logic wrap;

    modport master (
        output tick_in, start_stop, clear, lap,
        input  tenths, sec_u, sec_t, min_u, min_t, running, wrap
    );

    modport slave (
        input  tick_in, start_stop, clear, lap,
        output tenths, sec_u, sec_t, min_u, min_t, running, wrap
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit, counting 0..MAX; carry flags the increment that rolls it over.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = DigitMax9
) (
    input  logic clk_in,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    bcd_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.t stopwatch advanced by rising edges of an asynchronous 10 Hz tick.
// Optional lap/display hold is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MAX_MIN_TENS = 5
) (
    input logic            clk_in,
    input logic            reset,
    stopwatch_bcd_if.slave sw
);

    // Tick synchroniser and rising-edge detector
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   tick_dly_q;
    logic                   tick_rise;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], sw.tick_in};
    assign tick_rise = sync_q[SYNC_STAGES-1] & ~tick_dly_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            tick_dly_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            tick_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Control FSM
    sw_state_e state_q, state_d;
    logic      running;
    logic      count_en;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sw.clear) begin
            state_d = StIdle;
        end else if (sw.start_stop) begin
            case (state_q)
                StIdle:  state_d = StRun;
                StRun:   state_d = StPause;
                StPause: state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // A tick coincident with start_stop in RUN still counts: it is judged on the current state.
    always_comb begin
        running  = 1'b0;
        count_en = 1'b0;
        if (state_q == StRun) begin
            running  = 1'b1;
            count_en = tick_rise & ~sw.clear;
        end
    end

    // Digit carry chain
    bcd_t live_tenths, live_sec_u, live_sec_t, live_min_u, live_min_t;
    logic c_tenths, c_sec_u, c_sec_t, c_min_u, c_min_t;

    bcd_digit_counter #(.MAX(DigitMax9)) u_tenths (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (sw.clear),
        .inc    (count_en),
        .digit  (live_tenths),
        .carry  (c_tenths)
    );

    bcd_digit_counter #(.MAX(DigitMax9)) u_sec_u (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (sw.clear),
        .inc    (c_tenths),
        .digit  (live_sec_u),
        .carry  (c_sec_u)
    );

    bcd_digit_counter #(.MAX(DigitMax5)) u_sec_t (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (sw.clear),
        .inc    (c_sec_u),
        .digit  (live_sec_t),
        .carry  (c_sec_t)
    );

    bcd_digit_counter #(.MAX(DigitMax9)) u_min_u (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (sw.clear),
        .inc    (c_sec_t),
        .digit  (live_min_u),
        .carry  (c_min_u)
    );

    bcd_digit_counter #(.MAX(bcd_t'(MAX_MIN_TENS))) u_min_t (
        .clk_in (clk_in),
        .reset  (reset),
        .clr    (sw.clear),
        .inc    (c_min_u),
        .digit  (live_min_t),
        .carry  (c_min_t)
    );

    // Carry out of the top digit is the full-count rollover; registering it aligns with 00:00.0.
    logic wrap_q;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= c_min_t;
        end
    end

    bcd_t [4:0] live;
    bcd_t [4:0] disp;

    assign live = {live_min_t, live_min_u, live_sec_t, live_sec_u, live_tenths};

`ifdef STOPWATCH_LAP_EN
    logic       hold_q, hold_d;
    bcd_t [4:0] snap_q, snap_d;

    always_comb begin
        hold_d = hold_q;
        snap_d = snap_q;
        if (sw.clear) begin
            hold_d = 1'b0;
        end else if (sw.lap) begin
            hold_d = ~hold_q;
            if (!hold_q) begin
                snap_d = live;
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            hold_q <= 1'b0;
            snap_q <= '0;
        end else begin
            hold_q <= hold_d;
            snap_q <= snap_d;
        end
    end

    assign disp = hold_q ? snap_q : live;
`else
    logic unused_lap;

    assign unused_lap = sw.lap;
    assign disp       = live;
`endif

    assign sw.tenths  = disp[0];
    assign sw.sec_u   = disp[1];
    assign sw.sec_t   = disp[2];
    assign sw.min_u   = disp[3];
    assign sw.min_t   = disp[4];
    assign sw.running = running;
    assign sw.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench: a default stopwatch and one with MAX_MIN_TENS=0 share all stimulus.
module tb_stopwatch_bcd;
    import stopwatch_pkg::*;

    localparam int ModA   = 36000;
    localparam int ModW   = 6000;
    localparam int SIdle  = 0;
    localparam int SRun   = 1;
    localparam int SPause = 2;
`ifdef STOPWATCH_LAP_EN
    localparam bit LapOn = 1'b1;
`else
    localparam bit LapOn = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic reset;
    logic tick_v, ss_v, clr_v, lap_v;

    int checks   = 0;
    int failures = 0;

    // Reference model: elapsed tenths per instance, FSM state, lap hold
    int cnt_a, cnt_w, snap_a, snap_w, st;
    bit hold;

    stopwatch_bcd_if if_a ();
    stopwatch_bcd_if if_w ();

    assign if_a.tick_in    = tick_v;
    assign if_a.start_stop = ss_v;
    assign if_a.clear      = clr_v;
    assign if_a.lap        = lap_v;
    assign if_w.tick_in    = tick_v;
    assign if_w.start_stop = ss_v;
    assign if_w.clear      = clr_v;
    assign if_w.lap        = lap_v;

    stopwatch_bcd u_dut_a (
        .clk_in (clk_in),
        .reset  (reset),
        .sw     (if_a.slave)
    );

    stopwatch_bcd #(.SYNC_STAGES(2), .MAX_MIN_TENS(0)) u_dut_w (
        .clk_in (clk_in),
        .reset  (reset),
        .sw     (if_w.slave)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [19:0] to_bcd(input int c);
        return {4'(c / 6000), 4'((c / 600) % 10), 4'((c / 100) % 6), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [19:0] dig_a();
        return {if_a.min_t, if_a.min_u, if_a.sec_t, if_a.sec_u, if_a.tenths};
    endfunction

    function automatic logic [19:0] dig_w();
        return {if_w.min_t, if_w.min_u, if_w.sec_t, if_w.sec_u, if_w.tenths};
    endfunction

    function automatic int disp_a();
        return (LapOn && hold) ? snap_a : cnt_a;
    endfunction

    function automatic int disp_w();
        return (LapOn && hold) ? snap_w : cnt_w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " digits_a"}, 32'(dig_a()), 32'(to_bcd(disp_a())));
        chk({tag, " digits_w"}, 32'(dig_w()), 32'(to_bcd(disp_w())));
        chk({tag, " running_a"}, 32'(if_a.running), 32'(st == SRun));
        chk({tag, " running_w"}, 32'(if_w.running), 32'(st == SRun));
    endtask

    // One 4-cycle tick_in period starting at a falling clock edge; optional start_stop
    // is placed in the cycle where the synchronised rising edge is seen.
    task automatic tick_op(input bit coinc);
        logic [19:0] pa;
        bit          wa, ww;
        pa = to_bcd(disp_a());
        tick_v = 1'b1;
        @(negedge clk_in);
        chk("latency_edge1", 32'(dig_a()), 32'(pa));
        @(negedge clk_in);
        chk("latency_edge2", 32'(dig_a()), 32'(pa));
        tick_v = 1'b0;
        ss_v   = coinc;
        @(negedge clk_in);
        ss_v = 1'b0;
        wa   = 1'b0;
        ww   = 1'b0;
        if (st == SRun) begin
            cnt_a = (cnt_a + 1) % ModA;
            cnt_w = (cnt_w + 1) % ModW;
            wa    = (cnt_a == 0);
            ww    = (cnt_w == 0);
        end
        if (coinc) st = (st == SRun) ? SPause : SRun;
        check_model("tick_edge3");
        chk("wrap_edge3_a", 32'(if_a.wrap), 32'(wa));
        chk("wrap_edge3_w", 32'(if_w.wrap), 32'(ww));
        @(negedge clk_in);
        chk("wrap_edge4_a", 32'(if_a.wrap), 32'd0);
        chk("wrap_edge4_w", 32'(if_w.wrap), 32'd0);
    endtask

    task automatic pulse_op(input bit ss, input bit clr, input bit lap);
        ss_v  = ss;
        clr_v = clr;
        lap_v = lap;
        @(negedge clk_in);
        ss_v  = 1'b0;
        clr_v = 1'b0;
        lap_v = 1'b0;
        if (clr) begin
            cnt_a = 0;
            cnt_w = 0;
            st    = SIdle;
            hold  = 1'b0;
        end else begin
            if (ss) st = (st == SRun) ? SPause : SRun;
            if (lap && LapOn) begin
                if (!hold) begin
                    snap_a = cnt_a;
                    snap_w = cnt_w;
                end
                hold = !hold;
            end
        end
        check_model("pulse");
    endtask

    typedef enum int {OpTicks, OpSs, OpClr, OpClrSs} op_e;
    typedef struct {
        op_e         op;
        int          n;
        logic [19:0] exp_dig;
        bit          exp_run;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int r;
        vecs[0]  = '{OpTicks, 5,    20'h00000, 1'b0};
        vecs[1]  = '{OpSs,    1,    20'h00000, 1'b1};
        vecs[2]  = '{OpTicks, 125,  20'h00125, 1'b1};
        vecs[3]  = '{OpSs,    1,    20'h00125, 1'b0};
        vecs[4]  = '{OpTicks, 10,   20'h00125, 1'b0};
        vecs[5]  = '{OpSs,    1,    20'h00125, 1'b1};
        vecs[6]  = '{OpTicks, 5,    20'h00130, 1'b1};
        vecs[7]  = '{OpClr,   1,    20'h00000, 1'b0};
        vecs[8]  = '{OpSs,    1,    20'h00000, 1'b1};
        vecs[9]  = '{OpTicks, 673,  20'h01073, 1'b1};
        vecs[10] = '{OpClrSs, 1,    20'h00000, 1'b0};
        vecs[11] = '{OpTicks, 3,    20'h00000, 1'b0};
        vecs[12] = '{OpSs,    1,    20'h00000, 1'b1};
        vecs[13] = '{OpTicks, 5998, 20'h09598, 1'b1};

        reset  = 1'b0;
        tick_v = 1'b0;
        ss_v   = 1'b0;
        clr_v  = 1'b0;
        lap_v  = 1'b0;
        cnt_a  = 0;
        cnt_w  = 0;
        snap_a = 0;
        snap_w = 0;
        st     = SIdle;
        hold   = 1'b0;

        // Reset held while tick_in keeps toggling
        repeat (2) @(negedge clk_in);
        repeat (3) begin
            tick_v = 1'b1;
            repeat (2) @(negedge clk_in);
            tick_v = 1'b0;
            repeat (2) @(negedge clk_in);
        end
        chk("reset digits_a", 32'(dig_a()), 32'd0);
        chk("reset digits_w", 32'(dig_w()), 32'd0);
        chk("reset running", 32'(if_a.running), 32'd0);
        chk("reset wrap", 32'(if_a.wrap), 32'd0);
        reset = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 14; i++) begin
            case (vecs[i].op)
                OpTicks: repeat (vecs[i].n) tick_op(1'b0);
                OpSs:    pulse_op(1'b1, 1'b0, 1'b0);
                OpClr:   pulse_op(1'b0, 1'b1, 1'b0);
                default: pulse_op(1'b1, 1'b1, 1'b0);
            endcase
            chk($sformatf("vec%0d digits", i), 32'(dig_a()), 32'(vecs[i].exp_dig));
            chk($sformatf("vec%0d running", i), 32'(if_a.running), 32'(vecs[i].exp_run));
        end

        // Full count on the MAX_MIN_TENS=0 instance: 09:59.8 -> 09:59.9 -> 00:00.0
        chk("w_preload", 32'(dig_w()), 32'h09598);
        tick_op(1'b0);
        chk("w_full", 32'(dig_w()), 32'h09599);
        tick_op(1'b0);
        chk("w_wrapped", 32'(dig_w()), 32'h00000);
        chk("a_rolled", 32'(dig_a()), 32'h10000);
        chk("w_still_run", 32'(if_w.running), 32'd1);

        // start_stop coincident with a tick: counted in RUN, not counted when resuming
        tick_op(1'b1);
        chk("coinc_pause", 32'(dig_a()), 32'h10001);
        tick_op(1'b1);
        chk("coinc_resume", 32'(dig_a()), 32'h10001);

        // Lap hold
        pulse_op(1'b0, 1'b1, 1'b0);
        pulse_op(1'b1, 1'b0, 1'b0);
        repeat (42) tick_op(1'b0);
        pulse_op(1'b0, 1'b0, 1'b1);
        chk("lap_snap", 32'(dig_a()), 32'h00042);
        repeat (30) tick_op(1'b0);
`ifdef STOPWATCH_LAP_EN
        chk("lap_hold", 32'(dig_a()), 32'h00042);
`else
        chk("lap_ignored", 32'(dig_a()), 32'h00072);
`endif
        pulse_op(1'b0, 1'b0, 1'b1);
        chk("lap_release", 32'(dig_a()), 32'h00072);

        // Randomised mix against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            if (r < 10) begin
                tick_op(r == 9);
            end else if (r < 12) begin
                pulse_op(1'b1, 1'b0, 1'b0);
            end else if (r == 12) begin
                pulse_op(1'b0, 1'b1, 1'b0);
            end else if (r == 13) begin
                pulse_op(1'b1, 1'b1, 1'b0);
            end else if (r == 14) begin
                pulse_op(1'b0, 1'b0, 1'b1);
            end else begin
                repeat ($urandom_range(1, 3)) @(negedge clk_in);
                check_model("idle");
            end
        end

        // Asynchronous reset mid-count
        pulse_op(1'b0, 1'b1, 1'b0);
        pulse_op(1'b1, 1'b0, 1'b0);
        repeat (3) tick_op(1'b0);
        @(posedge clk_in);
        #2 reset = 1'b0;
        #1;
        chk("async_reset digits_a", 32'(dig_a()), 32'd0);
        chk("async_reset digits_w", 32'(dig_w()), 32'd0);
        chk("async_reset running", 32'(if_a.running), 32'd0);
        @(negedge clk_in);
        reset = 1'b1;
        cnt_a = 0;
        cnt_w = 0;
        st    = SIdle;
        hold  = 1'b0;
        @(negedge clk_in);
        tick_op(1'b0);
        pulse_op(1'b1, 1'b0, 1'b0);
        tick_op(1'b0);
        chk("post_reset count", 32'(dig_a()), 32'h00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

BCD stopwatch counting MM:SS.t (minutes, seconds, tenths) from the 10 Hz square wave produced by the lab's clock divider stage. The divided clock is treated as data: it is synchronised into `clk_in`, edge-detected, and each rising edge advances the count by one tenth while running. Digit outputs feed the 7-segment display driver. Start/stop and clear come from debounced, single-cycle button pulses.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `tick_in` synchroniser (≥2).
- `MAX_MIN_TENS`, 5: highest value of the minutes-tens digit before wrap.
- `clk_in`  input  1  system clock (100 MHz board clock).
- `reset`  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `tick_in`  input  1  divided clock (10 Hz square wave), asynchronous to `clk_in`.
- `start_stop`  input  1  single-cycle pulse; toggles counting.
- `clear`  input  1  single-cycle pulse; zeroes count, returns to IDLE.
- `lap`  input  1  single-cycle pulse; toggles display hold (only with `STOPWATCH_LAP_EN`).
- `tenths`, `sec_u`, `sec_t`, `min_u`, `min_t`  output  4 each  BCD digits.
- `running`  output  1  high in RUN.
- `wrap`  output  1  one-cycle pulse when 59:59.9 rolls to 00:00.0.

## Operation
- FSM states: IDLE, RUN, PAUSE. Reset → IDLE.
- IDLE: `start_stop` → RUN. PAUSE: `start_stop` → RUN. RUN: `start_stop` → PAUSE.
- `clear` in any state: all digits to 0, state → IDLE, lap hold released. `clear` and `start_stop` in the same cycle: `clear` wins.
- Tick: synchroniser output registered once more; `tick_rise` = sync_out & ~sync_d. In RUN, `tick_rise` increments tenths; outside RUN it is ignored, not queued.
- Cascade: tenths 0–9, sec_u 0–9, sec_t 0–5, min_u 0–9, min_t 0–`MAX_MIN_TENS`. Each digit increments only when all lower digits are at max and a tick occurs. Digits never leave BCD range.
- Wrap: at full count (default 59:59.9) next tick gives 00:00.0, `wrap` pulses, state stays RUN.
- `start_stop` coincident with `tick_rise` while in RUN: tick counted, then PAUSE. From PAUSE/IDLE: state → RUN, tick not counted.
- Reset mid-operation: all registers, including synchroniser, cleared immediately.

## Timing
- Reset values: all digits 0, `running`=0, `wrap`=0, FSM IDLE, synchroniser 0.
- `tick_in` rise → digit update on the (`SYNC_STAGES`+1)th `clk_in` rising edge after the sampling edge (3 cycles at default).
- `start_stop`/`clear` → state and `running` update on the next edge (1 cycle).
- `wrap` is registered, asserted in the same cycle the digits show 00:00.0.
- Ticks closer than `SYNC_STAGES`+2 `clk_in` cycles apart are not guaranteed; at 10 Hz vs 100 MHz this never arises.

## Configuration
- `STOPWATCH_LAP_EN` defined: `lap` toggles a hold flag; on hold assertion the five digits are snapshot into a display register and outputs show the snapshot while counting continues; second `lap` releases to live count next cycle. `clear` releases hold.
- Undefined: `lap` port present but ignored; outputs always show live count; no snapshot registers synthesised.

## Structure
- Package `stopwatch_pkg`: FSM state enum (IDLE, RUN, PAUSE), `bcd_t` (4-bit digit typedef), digit max constants (9, 5).
- Sub-module `bcd_digit_counter`: parameter MAX; inputs `clk_in`, `reset`, `clr`, `inc`; outputs `digit`, `carry` (= inc & digit==MAX). Instantiated five times in a carry chain.

## Test plan
- Reset with `tick_in` toggling → all digits 0, `running`=0; ticks ignored in IDLE.
- `start_stop`, then 125 `tick_in` rises → 00:12.5, `running`=1; each update exactly 3 cycles after the tick edge.
- At 00:12.5 pulse `start_stop`, apply 10 ticks → digits hold 00:12.5; `start_stop` again, 5 ticks → 00:13.0.
- Preload to 59:59.8 in RUN, 2 ticks → 59:59.9 then 00:00.0 with `wrap` high exactly one cycle.
- `clear` and `start_stop` same cycle while in RUN at 01:07.3 → 00:00.0, IDLE, `running`=0.
- With `STOPWATCH_LAP_EN`: `lap` at 00:04.2, 30 more ticks → outputs stay 00:04.2; second `lap` → 00:07.2.
